fir_mac_seq: RTL and testbench

Parametrised, time-multiplexed FIR filter core built around a single signed multiply-accumulate unit. It holds a TAPS-deep circular sample buffer and a writable coefficient memory, and accepts one input sample per valid/ready handshake. For each sample it computes one full convolution and presents the result on a valid/ready output port with backpressure. It sits between the sample source (input memory or streaming front end) and the result sink in the FIR datapath.

---
 rtl/fir_mac_seq.sv | 171 +++++++++++++++++
 tb/tb_fir_mac_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR core with one signed MAC.
// TAPS-deep circular sample history, writable coefficient memory,
// valid/ready sample input and valid/ready result output.
// Optional build macro FIR_ROUND_SAT_EN: round-half-up, shift by FRAC and
// saturate the result to DW bits (sign-extended to ACCW); otherwise the raw
// accumulator is presented.
module fir_mac_seq #(
  parameter int          DW   = 16,
  parameter int          CW   = 16,
  parameter int unsigned TAPS = 64,
  parameter int          ACCW = 40,
  parameter int          FRAC = 11,
  localparam int         AW   = $clog2(TAPS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_din,
  input  logic            buf_clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            busy
);

  localparam int PW = DW + CW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [AW:0]   TAPS_W   = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  logic [1:0]              state;
  logic signed [DW-1:0]    sbuf [TAPS];
  logic signed [CW-1:0]    coef [TAPS];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           new_ptr;
  logic [AW-1:0]           k;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr_nxt;
  logic signed [ACCW-1:0]  acc;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  out_res;
  logic                    idle;
  logic                    accept;
  logic                    coef_ok;

  assign idle     = (state == S_IDLE);
  // buf_clr has priority over a sample, so it also masks in_ready directly.
  assign in_ready = idle & ~buf_clr;
  assign accept   = in_ready & in_valid;
  assign busy     = ~idle;
  assign coef_ok  = idle & coef_we & ({1'b0, coef_addr} < TAPS_W);

  // Next write pointer and the history read index (newest_ptr - k) mod TAPS.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
    rd_ptr     = new_ptr - k;
    if (k > new_ptr)
      rd_ptr = AW'({1'b0, new_ptr} + TAPS_W - {1'b0, k});
  end

  // Full-precision signed product, sign-extended to the accumulator width.
  always_comb begin
    prod     = PW'(sbuf[rd_ptr]) * PW'(coef[k]);
    prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX  = (ACCW'(1) << (DW - 1)) - 1;
  localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

  logic signed [ACCW-1:0] rnd_sum;
  logic signed [ACCW-1:0] rnd_shift;

  // Round half up, arithmetic shift, clamp to the DW-bit signed range.
  always_comb begin
    rnd_sum   = acc + RND_HALF;
    rnd_shift = rnd_sum >>> FRAC;
    out_res   = rnd_shift;
    if (rnd_shift > SAT_MAX)
      out_res = SAT_MAX;
    else if (rnd_shift < SAT_MIN)
      out_res = SAT_MIN;
  end
`else
  // Raw accumulator is the result.
  always_comb begin
    out_res = acc;
  end
`endif

  // Coefficient memory: written only while idle, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < TAPS; i++)
        coef[i] <= '0;
    end else if (coef_ok) begin
      coef[coef_addr] <= coef_din;
    end
  end

  // Sample history: cleared by buf_clr or written on acceptance while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < TAPS; i++)
        sbuf[i] <= '0;
    end else if (idle && buf_clr) begin
      for (int unsigned i = 0; i < TAPS; i++)
        sbuf[i] <= '0;
    end else if (accept) begin
      sbuf[wr_ptr] <= in_data;
    end
  end

  // Control FSM, MAC accumulator and registered result port.
  // OUT spends one cycle loading out_data before out_valid is raised.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      new_ptr   <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (buf_clr) begin
            wr_ptr <= '0;
          end else if (in_valid) begin
            new_ptr <= wr_ptr;
            wr_ptr  <= wr_ptr_nxt;
            acc     <= '0;
            k       <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (k == LAST_TAP) begin
            k     <= '0;
            state <= S_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= out_res;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: scoreboard bench for fir_mac_seq at TAPS=4.
// Expected results come from a direct convolution over a newest-first
// sample history; a monitor pops and compares on each output handshake.
module tb_fir_mac_seq;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 4;
  localparam int ACCW = 40;
  localparam int FRAC = 11;
  localparam int AW   = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            coef_we = 1'b0;
  logic [AW-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_din = '0;
  logic            buf_clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [ACCW-1:0] out_data;
  logic            busy;

  fir_mac_seq #(.DW(DW), .CW(CW), .TAPS(TAPS), .ACCW(ACCW), .FRAC(FRAC)) dut (
    .clk(clk), .resetn(resetn), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_din(coef_din), .buf_clr(buf_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int nres   = 0;
  bit rand_ready = 1'b0;

  logic [ACCW-1:0] expq[$];
  longint mcoef [TAPS];
  longint mhist [TAPS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Direct convolution of the newest-first history with the coefficients.
  function automatic logic [ACCW-1:0] model_result();
    longint sum = 0;
    logic signed [ACCW-1:0] a;
    longint r;
    for (int i = 0; i < TAPS; i++) sum += mcoef[i] * mhist[i];
    a = sum[ACCW-1:0];
    r = longint'(a);
`ifdef FIR_ROUND_SAT_EN
    r = (r + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
    if (r < -(longint'(1) << (DW - 1)))    r = -(longint'(1) << (DW - 1));
`endif
    return ACCW'(r);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mcoef[i] = 0;
      mhist[i] = 0;
    end
  endfunction

  function automatic void model_accept(input logic [DW-1:0] v);
    for (int i = TAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
    mhist[0] = sx16(v);
    expq.push_back(model_result());
  endfunction

  // Monitor: compare on handshake, and check held outputs under backpressure.
  bit              hold_pending = 1'b0;
  logic [ACCW-1:0] held_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held_data);
        end
        if (out_valid && out_ready) begin
          nres++;
          if (expq.size() == 0) check("unexpected_output", out_data, 64'hDEAD);
          else check("result", out_data, expq.pop_front());
        end
        hold_pending = out_valid && !out_ready;
        held_data    = out_data;
      end
    end
  end

  // Random output backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy) return;
    end
    check("drain_timeout", expq.size(), 0);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] v);
    wait_idle();
    coef_we = 1'b1; coef_addr = a; coef_din = v;
    @(posedge clk);
    mcoef[a] = sx16(v);
    #1 coef_we = 1'b0;
  endtask

  task automatic clear_buf();
    wait_idle();
    buf_clr = 1'b1;
    #1 check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    for (int i = 0; i < TAPS; i++) mhist[i] = 0;
    #1 buf_clr = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    wait_idle();
    in_valid = 1'b1; in_data = v;
    @(posedge clk);
    model_accept(v);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_with_coef(input logic [DW-1:0] v, input logic [AW-1:0] a, input logic [CW-1:0] c);
    wait_idle();
    in_valid = 1'b1; in_data = v;
    coef_we = 1'b1; coef_addr = a; coef_din = c;
    @(posedge clk);
    mcoef[a] = sx16(c);
    model_accept(v);
    #1 begin in_valid = 1'b0; coef_we = 1'b0; end
  endtask

  int lat;
  int n0;
  logic [ACCW-1:0] first_data;
  bit rdy_low;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Impulse response with coefficients 1..4.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), CW'(i + 1));
    send(16'd1);
    repeat (4) send(16'd0);
    drain();

    // Latency and backpressure.
    out_ready = 1'b0;
    clear_buf();
    n0 = nres;
    wait_idle();
    in_valid = 1'b1; in_data = 16'd7;
    @(posedge clk);
    model_accept(16'd7);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (in_ready) rdy_low = 1'b0;
      if (out_valid) begin
        lat = n - 1;
        break;
      end
    end
    check("latency", lat, TAPS + 1);
    check("in_ready_low_mac", rdy_low, 1);
    first_data = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, first_data);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("one_output", nres - n0, 1);

    // Wrap and clear with unit coefficients.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'd1);
    clear_buf();
    for (int s = 1; s <= 6; s++) send(DW'(s));
    clear_buf();
    send(16'd5);
    drain();

    // buf_clr wins over a simultaneous sample.
    wait_idle();
    buf_clr = 1'b1; in_valid = 1'b1; in_data = 16'd9;
    #1 check("clr_vs_valid_ready", in_ready, 0);
    @(posedge clk);
    for (int i = 0; i < TAPS; i++) mhist[i] = 0;
    #1 begin buf_clr = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    check("clr_vs_valid_busy", busy, 0);
    send(16'd3);
    drain();

    // Coefficient write on the acceptance edge is used by that computation.
    send_with_coef(16'd2, 2'd0, 16'd11);
    drain();

    // Coefficient write while busy is dropped.
    write_coef(2'd0, 16'd3);
    clear_buf();
    send(16'd2);
    @(negedge clk);
    check("busy_in_mac", busy, 1);
    coef_we = 1'b1; coef_addr = 2'd0; coef_din = 16'd9;
    @(posedge clk);
    #1 coef_we = 1'b0;
    drain();
    send(16'd1);
    drain();

    // Rounding / saturation corner values.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'd0);
    write_coef(2'd0, 16'h7FFF); clear_buf(); send(16'h7FFF); drain();
    write_coef(2'd0, 16'h0400); clear_buf(); send(16'h0001); drain();
    write_coef(2'd0, 16'h8000); clear_buf(); send(16'h7FFF); drain();

    // Reset during MAC loses the result and clears coefficients.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), CW'(i + 5));
    send(16'd4);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    expq.delete();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    send(16'd1);
    repeat (3) send(16'd0);
    drain();

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)       write_coef(AW'($urandom_range(0, TAPS - 1)), CW'($urandom));
      else if (r == 2) clear_buf();
      else if (r == 3) send_with_coef(DW'($urandom), AW'($urandom_range(0, TAPS - 1)), CW'($urandom));
      else             send(DW'($urandom));
    end
    rand_ready = 1'b0;
    #1 out_ready = 1'b1;
    drain();
    check("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
